spi_upcounter_dp: RTL and testbench
===================================

Name: spi_upcounter_dp

Overview:
- Datapath stage directly downstream of the up-counter control unit.
- Consumes the level-type run/stop and clear controls.
- Generates the count tick from a prescaler and maintains a wrapping decimal-range up-counter.
- Serialises each new count value as a two-byte frame (high byte, then low byte) to the SPI master byte transmitter.

Parameters:
- TICK_DIV, 10_000_000, clk cycles per count tick (100 MHz -> 10 Hz); must be >= 2.
- COUNT_MAX, 9999, terminal count before wrap to 0; must be < 65536.
- CNT_W, $clog2(COUNT_MAX+1) (14 by default), counter width; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_runstop  in  1  level from control unit; 1 = count enabled
- i_clear  in  1  level from control unit; 1 = force count and prescaler to 0
- i_tx_ready  in  1  SPI master idle, may accept a start
- i_tx_done  in  1  one-cycle pulse, SPI master byte finished
- o_tx_start  out  1  one-cycle start pulse to SPI master
- o_tx_data  out  8  byte to transmit; stable from start until matching done
- o_count  out  CNT_W  live counter value
- o_busy  out  1  transmit FSM not in IDLE

Behaviour:
- Reset is asynchronous, active-high; clock is clk; all registers reset together. Reset values:
  - o_count = 0, prescaler = 0
  - o_tx_start = 0, o_tx_data = 0x00, o_busy = 0
  - FSM = IDLE, pending = 1, so the value 0 is sent once after reset.
- Prescaler:
  - Advances only while i_runstop = 1 and i_clear = 0.
  - tick = 1 for one cycle when prescaler == TICK_DIV-1; the prescaler returns to 0 on that cycle.
  - i_runstop = 0 holds the prescaler; it is not cleared.
- Counter:
  - Updates on the cycle after tick is registered (count register is written on the tick cycle edge).
  - Next value = 0 if count == COUNT_MAX, otherwise count+1.
- Clear:
  - i_clear = 1 forces count = 0 and prescaler = 0 on the next edge.
  - Clear has priority over a simultaneous tick.
  - Clear is effective regardless of i_runstop.
- pending flag:
  - Set on every tick edge and every cycle that i_clear = 1.
  - Cleared when the FSM latches a snapshot.
  - A set and a clear in the same cycle leave pending = 1 (set wins).
- Transmit FSM states: IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO.
  - IDLE: if pending = 1, latch snapshot = o_count, clear pending, go to SEND_HI.
  - SEND_HI: o_tx_data = snapshot[15:8] (zero-extended from CNT_W). When i_tx_ready = 1, o_tx_start = 1 for exactly that cycle and go to WAIT_HI; otherwise wait.
  - WAIT_HI: hold o_tx_data; on i_tx_done go to SEND_LO.
  - SEND_LO: o_tx_data = snapshot[7:0]; start issued as in SEND_HI, then go to WAIT_LO.
  - WAIT_LO: on i_tx_done go to IDLE.
  - i_tx_done outside the WAIT states is ignored.
- Frame content and coalescing:
  - Frames carry the snapshot value, never the live count.
  - Count changes during a frame are coalesced: one follow-up frame carries the latest value at the next IDLE latch.
- o_tx_start is registered; it is never high in two consecutive cycles.
- o_busy is 1 in every state except IDLE.
- Reset mid-frame:
  - o_tx_start drops immediately (asynchronously).
  - FSM returns to IDLE; the frame is abandoned.
  - The frame for value 0 is reissued after reset is released.

Test Plan:
1. Reset release, i_tx_ready = 1, i_tx_done pulsed 3 cycles after each start, i_runstop = i_clear = 0 -> o_count = 0; frame bytes 0x00, 0x00 with exactly two start pulses; o_busy returns to 0.
2. TICK_DIV = 4, i_runstop = 1 for 12 cycles then 0 -> o_count = 3; prescaler holds; o_count stays 3 for 20 further cycles.
3. COUNT_MAX = 15, TICK_DIV = 2, run from 14 -> 15, then the following tick yields 0; frames 0x00,0x0F then 0x00,0x00.
4. Count = 7 with i_clear = 1 on the same cycle as tick -> o_count = 0 on the next edge, prescaler = 0; next transmitted frame 0x00, 0x00.
5. Snapshot 6699 (0x1A2B); i_tx_ready held low 5 cycles in SEND_HI; three ticks occur during the frame -> bytes 0x1A then 0x2B; o_tx_start asserted only while i_tx_ready = 1; o_tx_data stable through each WAIT state; exactly one follow-up frame carrying 6702.
6. Reset asserted in WAIT_LO -> o_tx_start = 0, o_busy = 0, o_count = 0 immediately; after release one frame 0x00, 0x00.

Source files
------------

// File: rtl/spi_upcounter_dp_if.sv
// Byte-level handshake between the up-counter datapath and the SPI master byte transmitter.
// The datapath is the master: it offers bytes, the transmitter reports ready/done.
interface spi_upcounter_dp_if;
  logic       i_tx_ready;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;

  modport master (
    input  i_tx_ready,
    input  i_tx_done,
    output o_tx_start,
    output o_tx_data
  );

  modport slave (
    output i_tx_ready,
    output i_tx_done,
    input  o_tx_start,
    input  o_tx_data
  );
endinterface

// File: rtl/spi_upcounter_dp.sv
// Prescaled wrapping up-counter that ships every new value to the SPI master as a
// two-byte frame (high byte first); changes made while a frame is in flight coalesce.
module spi_upcounter_dp #(
  parameter  int TICK_DIV  = 10_000_000,
  parameter  int COUNT_MAX = 9999,
  localparam int CNT_W     = $clog2(COUNT_MAX + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_runstop,
  input  logic                i_clear,
  spi_upcounter_dp_if.master  tx,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_busy
);

  localparam int PRE_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
  } state_t;

  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic             tick;
  logic             latch;
  logic [15:0]      count_ext;

  state_t           state_q, state_d;
  logic [7:0]       snap_lo_q, snap_lo_d;
  logic [7:0]       data_q, data_d;
  logic             start_q, start_d;

  assign tick      = i_runstop & ~i_clear & (pre_q == PRE_W'(TICK_DIV - 1));
  assign latch     = (state_q == IDLE) & pending_q;
  assign count_ext = 16'(count_q);

  // Clear beats a coincident tick; a stopped prescaler keeps its phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (i_clear) begin
      pre_q   <= '0;
      count_q <= '0;
    end else if (i_runstop) begin
      if (tick) begin
        pre_q   <= '0;
        count_q <= (count_q == CNT_W'(COUNT_MAX)) ? '0 : count_q + CNT_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  // Set wins over the latch so a change in the latch cycle still earns a follow-up frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b1;
    end else if (tick || i_clear) begin
      pending_q <= 1'b1;
    end else if (latch) begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      snap_lo_q <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_lo_q <= snap_lo_d;
      data_q    <= data_d;
      start_q   <= start_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_lo_d = snap_lo_q;
    data_d    = data_q;
    start_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          snap_lo_d = count_ext[7:0];
          data_d    = count_ext[15:8];
          state_d   = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx.i_tx_ready) begin
          start_d = 1'b1;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx.i_tx_done) begin
          data_d  = snap_lo_q;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx.i_tx_ready) begin
          start_d = 1'b1;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (tx.i_tx_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx.o_tx_start = start_q;
  assign tx.o_tx_data  = data_q;
  assign o_count       = count_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_upcounter_dp.sv
// Drives two counter instances (fast-wrap and decimal) with directed vectors and checks
// them every cycle against a value-level model of counting, pickup and framing.
module tb_spi_upcounter_dp;

  localparam int DIV_A = 4;
  localparam int MAX_A = 9999;
  localparam int DIV_B = 2;
  localparam int MAX_B = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        runstop = 1'b0;
  logic        clear = 1'b0;
  logic        tx_ready = 1'b1;
  logic        done_v [2];
  logic [13:0] count_a;
  logic [3:0]  count_b;
  logic        busy_a, busy_b;

  spi_upcounter_dp_if bus_a ();
  spi_upcounter_dp_if bus_b ();

  assign bus_a.i_tx_ready = tx_ready;
  assign bus_b.i_tx_ready = tx_ready;
  assign bus_a.i_tx_done  = done_v[0];
  assign bus_b.i_tx_done  = done_v[1];

  spi_upcounter_dp #(.TICK_DIV(DIV_A), .COUNT_MAX(MAX_A)) dut_a (
    .clk(clk), .reset(reset), .i_runstop(runstop), .i_clear(clear),
    .tx(bus_a), .o_count(count_a), .o_busy(busy_a)
  );

  spi_upcounter_dp #(.TICK_DIV(DIV_B), .COUNT_MAX(MAX_B)) dut_b (
    .clk(clk), .reset(reset), .i_runstop(runstop), .i_clear(clear),
    .tx(bus_b), .o_count(count_b), .o_busy(busy_b)
  );

  logic       start_w [2];
  logic       busy_w  [2];
  logic [7:0] data_w  [2];
  int         cnt_w   [2];

  assign start_w[0] = bus_a.o_tx_start;
  assign start_w[1] = bus_b.o_tx_start;
  assign data_w[0]  = bus_a.o_tx_data;
  assign data_w[1]  = bus_b.o_tx_data;
  assign busy_w[0]  = busy_a;
  assign busy_w[1]  = busy_b;
  assign cnt_w[0]   = 32'(count_a);
  assign cnt_w[1]   = 32'(count_b);

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model state: what the count must be, whether a change is still owed a frame,
  // and which value the frame now in flight must carry.
  int m_cnt [2];
  int m_pre [2];
  int exp_frame [2];
  bit m_pend [2];
  bit m_latched [2];
  bit m_ready_edge [2];

  // Observation state kept by the compare process.
  bit busy_seen [2];
  bit prev_start [2];
  bit in_wait [2];
  int bi [2];
  int hold [2];
  int first_byte [2];
  int starts [2];
  int frames_a [$];
  int frames_b [$];

  function automatic int last_frame(input int i);
    if (i == 0) return (frames_a.size() == 0) ? -1 : frames_a[frames_a.size() - 1];
    return (frames_b.size() == 0) ? -1 : frames_b[frames_b.size() - 1];
  endfunction

  // Behavioural model, advanced on each active edge.
  initial begin
    int dv, mx;
    bit tk;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_pend[i] = 1'b1; m_latched[i] = 1'b0;
      exp_frame[i] = 0; m_ready_edge[i] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          m_cnt[i] = 0; m_pre[i] = 0; m_pend[i] = 1'b1; m_latched[i] = 1'b0;
        end else begin
          dv = (i == 0) ? DIV_A : DIV_B;
          mx = (i == 0) ? MAX_A : MAX_B;
          tk = runstop && !clear && (m_pre[i] == dv - 1);
          m_latched[i] = !busy_seen[i] && m_pend[i];
          if (m_latched[i]) exp_frame[i] = m_cnt[i];
          m_ready_edge[i] = tx_ready;
          if (clear) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
          end else if (runstop) begin
            if (tk) begin
              m_pre[i] = 0;
              m_cnt[i] = (m_cnt[i] == mx) ? 0 : m_cnt[i] + 1;
            end else begin
              m_pre[i] = m_pre[i] + 1;
            end
          end
          if (tk || clear) m_pend[i] = 1'b1;
          else if (m_latched[i]) m_pend[i] = 1'b0;
        end
      end
    end
  end

  // SPI master stand-in: finishes each byte three cycles after its start pulse.
  initial begin
    int rcnt [2];
    for (int i = 0; i < 2; i++) begin
      rcnt[i] = 0;
      done_v[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          rcnt[i] = 0;
          done_v[i] = 1'b0;
        end else begin
          done_v[i] = 1'b0;
          if (rcnt[i] > 0) begin
            rcnt[i] = rcnt[i] - 1;
            if (rcnt[i] == 0) done_v[i] = 1'b1;
          end
          if (start_w[i]) rcnt[i] = 3;
        end
      end
    end
  end

  // Compare process: every cycle, both instances against the model.
  initial begin
    int e;
    for (int i = 0; i < 2; i++) begin
      busy_seen[i] = 1'b0; prev_start[i] = 1'b0; in_wait[i] = 1'b0;
      bi[i] = 0; hold[i] = 0; first_byte[i] = 0; starts[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          busy_seen[i] = 1'b0; prev_start[i] = 1'b0; in_wait[i] = 1'b0; bi[i] = 0;
        end else begin
          check_output("count", cnt_w[i], m_cnt[i]);
          if (!busy_seen[i]) check_output("busy_pickup", 32'(busy_w[i]), 32'(m_latched[i]));
          if (in_wait[i]) begin
            check_output("data_hold", 32'(data_w[i]), hold[i]);
            if (done_v[i]) in_wait[i] = 1'b0;
          end
          if (start_w[i]) begin
            starts[i]++;
            check_output("start_gap", 32'(prev_start[i]), 0);
            check_output("start_ready", 32'(m_ready_edge[i]), 1);
            check_output("start_busy", 32'(busy_w[i]), 1);
            e = (bi[i] == 0) ? ((exp_frame[i] >> 8) & 255) : (exp_frame[i] & 255);
            check_output("tx_byte", 32'(data_w[i]), e);
            hold[i] = 32'(data_w[i]);
            in_wait[i] = 1'b1;
            if (bi[i] == 0) begin
              first_byte[i] = 32'(data_w[i]);
              bi[i] = 1;
            end else begin
              if (i == 0) frames_a.push_back((first_byte[i] << 8) | 32'(data_w[i]));
              else frames_b.push_back((first_byte[i] << 8) | 32'(data_w[i]));
              bi[i] = 0;
            end
          end
          prev_start[i] = start_w[i];
          busy_seen[i] = busy_w[i];
        end
      end
    end
  end

  task automatic apply_stimulus(input bit run, input bit clr, input bit rdy, input int cycles);
    runstop  = run;
    clear    = clr;
    tx_ready = rdy;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int n = 0; n < budget && quiet < 3; n++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) check_output("idle_timeout", quiet, 3);
  endtask

  task automatic wait_model_count(input int target, input int budget);
    bit hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      if (m_cnt[0] == target) hit = 1'b1;
    end
    if (!hit) check_output("count_timeout", m_cnt[0], target);
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, s, nb;
    bit hit;

    // Reset values, then the single frame for value 0.
    apply_stimulus(1'b0, 1'b0, 1'b1, 2);
    check_output("rst_count_a", cnt_w[0], 0);
    check_output("rst_count_b", cnt_w[1], 0);
    check_output("rst_busy", 32'(busy_a), 0);
    check_output("rst_start", 32'(bus_a.o_tx_start), 0);
    check_output("rst_data", 32'(bus_a.o_tx_data), 0);
    #1 reset = 1'b0;
    wait_idle(100);
    check_output("boot_frames", frames_a.size(), 1);
    check_output("boot_frame_val", last_frame(0), 0);
    check_output("boot_starts", starts[0], 2);
    check_output("boot_busy", 32'(busy_a), 0);

    // Twelve running cycles at divide-by-4, then a held prescaler.
    apply_stimulus(1'b1, 1'b0, 1'b1, 12);
    check_output("run12_count", cnt_w[0], 3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 20);
    check_output("stopped_count", cnt_w[0], 3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 10);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1);
    check_output("held_phase_count", cnt_w[0], 3);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1);
    check_output("held_phase_tick", cnt_w[0], 4);
    runstop = 1'b0;
    wait_idle(100);

    // Clear arriving on the tick cycle at count 7.
    apply_stimulus(1'b1, 1'b0, 1'b1, 15);
    check_output("pre_clear_count", cnt_w[0], 7);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1);
    runstop = 1'b0;
    clear = 1'b0;
    check_output("clear_wins", cnt_w[0], 0);
    wait_idle(100);
    check_output("clear_frame", last_frame(0), 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 3);
    check_output("clear_pre_zero", cnt_w[0], 0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1);
    check_output("clear_first_tick", cnt_w[0], 1);
    runstop = 1'b0;

    // Wrap at COUNT_MAX=15 on the divide-by-2 instance.
    apply_stimulus(1'b0, 1'b1, 1'b1, 1);
    clear = 1'b0;
    wait_idle(100);
    apply_stimulus(1'b1, 1'b0, 1'b1, 28);
    runstop = 1'b0;
    check_output("b_count14", cnt_w[1], 14);
    wait_idle(100);
    apply_stimulus(1'b1, 1'b0, 1'b1, 2);
    runstop = 1'b0;
    check_output("b_count15", cnt_w[1], 15);
    wait_idle(100);
    check_output("b_frame_000f", last_frame(1), 16'h000F);
    nb = frames_b.size();
    apply_stimulus(1'b1, 1'b0, 1'b1, 2);
    runstop = 1'b0;
    check_output("b_wrap", cnt_w[1], 0);
    wait_idle(100);
    check_output("b_frame_0000", last_frame(1), 0);
    check_output("b_wrap_frames", frames_b.size() - nb, 1);

    // Frame for 6699 with a stalled transmitter and three ticks in flight.
    runstop = 1'b1;
    wait_model_count(6698, 30000);
    runstop = 1'b0;
    wait_idle(200);
    tx_ready = 1'b0;
    base = frames_a.size();
    runstop = 1'b1;
    wait_model_count(6699, 20);
    hit = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      @(negedge clk);
      if (busy_a) hit = 1'b1;
    end
    check_output("stall_busy", 32'(busy_a), 1);
    #1 s = starts[0];
    repeat (4) @(negedge clk);
    #1 check_output("stall_no_start", starts[0] - s, 0);
    tx_ready = 1'b1;
    wait_model_count(6702, 40);
    runstop = 1'b0;
    wait_idle(200);
    check_output("stall_frame_count", frames_a.size() - base, 2);
    if (frames_a.size() >= base + 2) begin
      check_output("stall_frame_1a2b", frames_a[base], 16'h1A2B);
      check_output("stall_followup", frames_a[base + 1], 6702);
    end
    check_output("stall_final_count", cnt_w[0], 6702);

    // Reset landing in WAIT_LO abandons the frame and re-sends zero.
    apply_stimulus(1'b1, 1'b0, 1'b1, 4);
    runstop = 1'b0;
    #1 s = starts[0];
    hit = 1'b0;
    for (int n = 0; n < 80 && !hit; n++) begin
      @(negedge clk);
      #1;
      if (starts[0] >= s + 2) hit = 1'b1;
    end
    check_output("reach_wait_lo", starts[0] - s, 2);
    check_output("pre_reset_busy", 32'(busy_a), 1);
    reset = 1'b1;
    #1;
    check_output("mid_reset_start", 32'(bus_a.o_tx_start), 0);
    check_output("mid_reset_busy", 32'(busy_a), 0);
    check_output("mid_reset_count", cnt_w[0], 0);
    check_output("mid_reset_data", 32'(bus_a.o_tx_data), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    base = frames_a.size();
    wait_idle(100);
    check_output("post_reset_frames", frames_a.size() - base, 1);
    check_output("post_reset_frame", last_frame(0), 0);
    check_output("post_reset_count", cnt_w[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
